pulse_sequence_monitor: RTL and testbench

- Receive-side checker and decoder for the 8-bit pulse-pattern bus and measure trigger produced by the pulse state machine.
- Decodes each pattern into a phase code and measures how long each phase is held, in clocks.
- Checks the 16-phase Reset/Write/Measure sequence and the trigger placement.
- Sits on the same clock as the generator, in loopback/verification and monitoring paths. Results go to status registers.

---
 rtl/pulse_pkg.sv | 35 +++
 rtl/pulse_pattern_decode.sv | 22 ++
 rtl/pulse_sequence_monitor.sv | 166 ++++++++++++++++
 tb/tb_pulse_sequence_monitor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared pulse-bus definitions: pattern encodings, phase codes, the 16-phase
// expected sequence and the mask of phases that carry a measure trigger.
package pulse_pkg;

    localparam int unsigned PAT_W    = 8;
    localparam int unsigned CODE_W   = 3;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned N_PHASES = 16;

    localparam logic [CODE_W-1:0] CODE_IDLE = 3'd0;
    localparam logic [CODE_W-1:0] CODE_RPOS = 3'd1;
    localparam logic [CODE_W-1:0] CODE_MEAS = 3'd2;
    localparam logic [CODE_W-1:0] CODE_WNEG = 3'd3;
    localparam logic [CODE_W-1:0] CODE_RNEG = 3'd4;
    localparam logic [CODE_W-1:0] CODE_WPOS = 3'd5;
    localparam logic [CODE_W-1:0] CODE_BAD  = 3'd7;

    localparam logic [PAT_W-1:0] PAT_IDLE = 8'b1000_0001;
    localparam logic [PAT_W-1:0] PAT_RPOS = 8'b1000_1001;
    localparam logic [PAT_W-1:0] PAT_MEAS = 8'b1000_0101;
    localparam logic [PAT_W-1:0] PAT_WNEG = 8'b1001_0001;
    localparam logic [PAT_W-1:0] PAT_RNEG = 8'b1010_0001;
    localparam logic [PAT_W-1:0] PAT_WPOS = 8'b1000_0011;

    localparam logic [CODE_W-1:0] EXP_SEQ [N_PHASES] = '{
        CODE_RPOS, CODE_IDLE, CODE_MEAS, CODE_IDLE,
        CODE_WNEG, CODE_IDLE, CODE_MEAS, CODE_IDLE,
        CODE_RNEG, CODE_IDLE, CODE_MEAS, CODE_IDLE,
        CODE_WPOS, CODE_IDLE, CODE_MEAS, CODE_IDLE
    };

    // Bit i set: entering phase i must be followed one clock later by a trigger.
    localparam logic [N_PHASES-1:0] TRIG_MASK = 16'b0000_0000_0100_0100;

endpackage

// File: rtl/pulse_pattern_decode.sv
// Combinational pattern-to-phase-code decoder; unknown patterns map to BAD.
module pulse_pattern_decode
    import pulse_pkg::*;
(
    input  logic [PAT_W-1:0]  pattern_i,
    output logic [CODE_W-1:0] code_o
);

    always_comb begin
        code_o = CODE_BAD;
        case (pattern_i)
            PAT_IDLE: code_o = CODE_IDLE;
            PAT_RPOS: code_o = CODE_RPOS;
            PAT_MEAS: code_o = CODE_MEAS;
            PAT_WNEG: code_o = CODE_WNEG;
            PAT_RNEG: code_o = CODE_RNEG;
            PAT_WPOS: code_o = CODE_WPOS;
            default:  code_o = CODE_BAD;
        endcase
    end

endmodule

// File: rtl/pulse_sequence_monitor.sv
// Receive-side monitor for the pulse-pattern bus: decodes phases, measures their
// length, checks the 16-phase sequence and trigger placement, and counts events.
module pulse_sequence_monitor
    import pulse_pkg::*;
#(
    parameter int unsigned DUR_W = 22,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [PAT_W-1:0]  signal_in,
    input  logic              trigger_in,
    output logic              locked,
    output logic              phase_valid,
    output logic [IDX_W-1:0]  phase_index,
    output logic [CODE_W-1:0] phase_code,
    output logic [DUR_W-1:0]  phase_dur,
    output logic              seq_error,
    output logic              trig_error,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  error_count
);

    localparam int unsigned CNT_XW = CNT_W + 1;

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    logic [PAT_W-1:0]  s_q, s_prev_q;
    logic              t_q;
    logic [CODE_W-1:0] code_prev_q;
    logic [CODE_W-1:0] cur_code_c;
    logic              boundary_c;

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  exp_idx_q, exp_idx_d, next_idx_c;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              trig_due_q, trig_due_d;
    logic              pv_q, pv_d;
    logic [IDX_W-1:0]  pidx_q, pidx_d;
    logic [CODE_W-1:0] pcode_q, pcode_d;
    logic [DUR_W-1:0]  pdur_q, pdur_d;
    logic              seq_err_q, seq_err_d;
    logic              trig_err_q, trig_err_d;
    logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [1:0]        err_inc_c;
    logic [CNT_XW-1:0] err_sum_c;

    pulse_pattern_decode u_decode (
        .pattern_i (s_q),
        .code_o    (cur_code_c)
    );

    assign boundary_c = (s_q != s_prev_q);
    assign next_idx_c = exp_idx_q + IDX_W'(1);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            s_q         <= '0;
            s_prev_q    <= '0;
            t_q         <= 1'b0;
            code_prev_q <= CODE_IDLE;
            state_q     <= ST_UNLOCKED;
            exp_idx_q   <= '0;
            dur_q       <= '0;
            trig_due_q  <= 1'b0;
            pv_q        <= 1'b0;
            pidx_q      <= '0;
            pcode_q     <= '0;
            pdur_q      <= '0;
            seq_err_q   <= 1'b0;
            trig_err_q  <= 1'b0;
            cyc_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            s_q         <= signal_in;
            s_prev_q    <= s_q;
            t_q         <= trigger_in;
            code_prev_q <= cur_code_c;
            state_q     <= state_d;
            exp_idx_q   <= exp_idx_d;
            dur_q       <= dur_d;
            trig_due_q  <= trig_due_d;
            pv_q        <= pv_d;
            pidx_q      <= pidx_d;
            pcode_q     <= pcode_d;
            pdur_q      <= pdur_d;
            seq_err_q   <= seq_err_d;
            trig_err_q  <= trig_err_d;
            cyc_cnt_q   <= cyc_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Next-state, phase reporting and error detection.
    always_comb begin
        state_d    = state_q;
        exp_idx_d  = exp_idx_q;
        trig_due_d = 1'b0;
        pv_d       = 1'b0;
        pidx_d     = pidx_q;
        pcode_d    = pcode_q;
        pdur_d     = pdur_q;
        seq_err_d  = 1'b0;
        trig_err_d = 1'b0;
        cyc_cnt_d  = cyc_cnt_q;

        if (boundary_c) begin
            dur_d = DUR_W'(1);
        end else if (&dur_q) begin
            dur_d = dur_q;
        end else begin
            dur_d = dur_q + DUR_W'(1);
        end

        case (state_q)
            ST_UNLOCKED: begin
                if (boundary_c && (cur_code_c == CODE_RPOS)) begin
                    state_d   = ST_LOCKED;
                    exp_idx_d = '0;
                end
            end
            ST_LOCKED: begin
                trig_err_d = (trig_due_q != t_q);
                if (boundary_c) begin
                    pv_d    = 1'b1;
                    pidx_d  = exp_idx_q;
                    pcode_d = code_prev_q;
                    pdur_d  = dur_q;
                    if (cur_code_c == EXP_SEQ[next_idx_c]) begin
                        exp_idx_d  = next_idx_c;
                        trig_due_d = TRIG_MASK[next_idx_c];
                        if ((exp_idx_q == IDX_W'(N_PHASES - 1)) && !(&cyc_cnt_q)) begin
                            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        // An RPOS onset is itself a valid lock point, so relock in place.
                        if (cur_code_c == CODE_RPOS) begin
                            exp_idx_d = '0;
                        end else begin
                            state_d = ST_UNLOCKED;
                        end
                    end
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase

        err_inc_c = {1'b0, seq_err_d} + {1'b0, trig_err_d};
        err_sum_c = CNT_XW'(err_cnt_q) + CNT_XW'(err_inc_c);
        err_cnt_d = err_sum_c[CNT_XW-1] ? {CNT_W{1'b1}} : err_sum_c[CNT_W-1:0];
    end

    assign locked      = state_q;
    assign phase_valid = pv_q;
    assign phase_index = pidx_q;
    assign phase_code  = pcode_q;
    assign phase_dur   = pdur_q;
    assign seq_error   = seq_err_q;
    assign trig_error  = trig_err_q;
    assign cycle_count = cyc_cnt_q;
    assign error_count = err_cnt_q;

endmodule

// File: tb/tb_pulse_sequence_monitor.sv
// Directed bench for pulse_sequence_monitor with a phase-report scoreboard.
module tb_pulse_sequence_monitor;

    localparam int unsigned DUR_W = 10;
    localparam int unsigned CNT_W = 16;
    localparam int          DMAX  = (1 << DUR_W) - 1;

    localparam logic [7:0] P_IDLE = 8'b1000_0001;
    localparam logic [7:0] P_RPOS = 8'b1000_1001;
    localparam logic [7:0] P_MEAS = 8'b1000_0101;
    localparam logic [7:0] P_WNEG = 8'b1001_0001;
    localparam logic [7:0] P_RNEG = 8'b1010_0001;
    localparam logic [7:0] P_WPOS = 8'b1000_0011;

    typedef struct {
        int idx;
        int code;
        int dur;
    } rec_t;

    logic             clk_in = 1'b0;
    logic             reset;
    logic [7:0]       signal_in;
    logic             trigger_in;
    logic             locked;
    logic             phase_valid;
    logic [3:0]       phase_index;
    logic [2:0]       phase_code;
    logic [DUR_W-1:0] phase_dur;
    logic             seq_error;
    logic             trig_error;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] error_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_seq    = 0;
    int   n_trig   = 0;
    rec_t exp_q[$];
    rec_t pend_rec;
    bit   pend_valid = 1'b0;
    logic lk [2];
    logic [7:0] seq_pat  [16];
    int         seq_code [16];

    pulse_sequence_monitor #(.DUR_W(DUR_W), .CNT_W(CNT_W)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .signal_in   (signal_in),
        .trigger_in  (trigger_in),
        .locked      (locked),
        .phase_valid (phase_valid),
        .phase_index (phase_index),
        .phase_code  (phase_code),
        .phase_dur   (phase_dur),
        .seq_error   (seq_error),
        .trig_error  (trig_error),
        .cycle_count (cycle_count),
        .error_count (error_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; sample #1 after the edge and score any phase report.
    task automatic tick();
        rec_t r;
        @(posedge clk_in);
        #1;
        n_seq  += int'(seq_error);
        n_trig += int'(trig_error);
        if (phase_valid) begin
            if (exp_q.size() == 0) begin
                check("valid_unexpected", int'(phase_valid), 0);
            end else begin
                r = exp_q.pop_front();
                check("phase_index", int'(phase_index), r.idx);
                check("phase_code",  int'(phase_code),  r.code);
                check("phase_dur",   int'(phase_dur),   r.dur);
            end
        end
    endtask

    task automatic phase(input logic [7:0] pat, input int len, input int tpos,
                         input bit report, input int idx, input int code);
        if (pend_valid) exp_q.push_back(pend_rec);
        pend_valid   = report;
        pend_rec.idx  = idx;
        pend_rec.code = code;
        pend_rec.dur  = (len > DMAX) ? DMAX : len;
        for (int i = 0; i < len; i++) begin
            signal_in  = pat;
            trigger_in = (i == tpos);
            tick();
            if (i < 2) lk[i] = locked;
        end
        trigger_in = 1'b0;
    endtask

    task automatic run_seq(input int first, input int last, input bit report,
                           input int drop, input int add);
        int tpos;
        for (int i = first; i <= last; i++) begin
            tpos = ((((i == 2) || (i == 6)) && (i != drop)) || (i == add)) ? 1 : -1;
            phase(seq_pat[i], 4, tpos, report, i, seq_code[i]);
        end
    endtask

    task automatic check_reset_state();
        check("rst_locked",      int'(locked),      0);
        check("rst_phase_valid", int'(phase_valid), 0);
        check("rst_phase_index", int'(phase_index), 0);
        check("rst_phase_code",  int'(phase_code),  0);
        check("rst_phase_dur",   int'(phase_dur),   0);
        check("rst_seq_error",   int'(seq_error),   0);
        check("rst_trig_error",  int'(trig_error),  0);
        check("rst_cycle_count", int'(cycle_count), 0);
        check("rst_error_count", int'(error_count), 0);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        signal_in  = '0;
        trigger_in = 1'b0;
        pend_valid = 1'b0;
        tick();
        reset = 1'b0;
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        n_seq  = 0;
        n_trig = 0;
        check_reset_state();
    endtask

    task automatic settle(input string tag);
        repeat (3) tick();
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        seq_pat  = '{P_RPOS, P_IDLE, P_MEAS, P_IDLE, P_WNEG, P_IDLE, P_MEAS, P_IDLE,
                     P_RNEG, P_IDLE, P_MEAS, P_IDLE, P_WPOS, P_IDLE, P_MEAS, P_IDLE};
        seq_code = '{1, 0, 2, 0, 3, 0, 2, 0, 4, 0, 2, 0, 5, 0, 2, 0};
        reset      = 1'b1;
        signal_in  = '0;
        trigger_in = 1'b0;
        repeat (2) tick();
        do_reset();

        // Nominal: two full sequences of 4-clock phases
        run_seq(0, 15, 1'b1, -1, -1);
        run_seq(0, 15, 1'b1, -1, -1);
        phase(P_RPOS, 4, -1, 1'b0, 0, 1);
        settle("nominal");
        check("nom_cycle_count", int'(cycle_count), 2);
        check("nom_error_count", int'(error_count), 0);
        check("nom_locked",      int'(locked),      1);
        check("nom_seq_errors",  n_seq,  0);
        check("nom_trig_errors", n_trig, 0);
        do_reset();

        // Lock acquisition from mid-sequence
        run_seq(5, 15, 1'b0, -1, -1);
        check("acq_locked_before", int'(locked), 0);
        phase(P_RPOS, 4, -1, 1'b1, 0, 1);
        check("acq_locked_edge1", int'(lk[0]), 0);
        check("acq_locked_edge2", int'(lk[1]), 1);
        run_seq(1, 3, 1'b1, -1, -1);
        settle("acq");
        check("acq_errors", int'(error_count), 0);
        do_reset();

        // Sequence error: WPOS in place of WNEG at index 4
        run_seq(0, 3, 1'b1, -1, -1);
        phase(P_WPOS, 4, -1, 1'b0, 4, 5);
        check("seq_locked_after", int'(locked),      0);
        check("seq_error_count",  int'(error_count), 1);
        check("seq_strobes",      n_seq,             1);
        run_seq(5, 15, 1'b0, -1, -1);
        run_seq(0, 15, 1'b1, -1, -1);
        phase(P_RPOS, 4, -1, 1'b0, 0, 1);
        settle("seq");
        check("seq_cycle_resume",  int'(cycle_count), 1);
        check("seq_error_final",   int'(error_count), 1);
        check("seq_strobes_final", n_seq,             1);
        check("seq_no_trig_err",   n_trig,            0);
        do_reset();

        // Trigger faults: dropped at phase 6, extra at phase 10
        run_seq(0, 7, 1'b1, 6, -1);
        check("trig_drop_count", n_trig,          1);
        check("trig_drop_lock",  int'(locked),    1);
        run_seq(8, 15, 1'b1, -1, 10);
        phase(P_RPOS, 4, -1, 1'b0, 0, 1);
        settle("trig");
        check("trig_extra_count", n_trig,              2);
        check("trig_locked",      int'(locked),        1);
        check("trig_error_count", int'(error_count),   2);
        check("trig_no_seq_err",  n_seq,               0);
        check("trig_cycle_count", int'(cycle_count),   1);
        do_reset();

        // Boundary durations: 1-clock MEAS and a saturating long phase
        run_seq(0, 1, 1'b1, -1, -1);
        phase(P_MEAS, 1, -1, 1'b1, 2, 2);
        phase(P_IDLE, 4, 0, 1'b1, 3, 0);
        phase(P_WNEG, DMAX + 6, -1, 1'b1, 4, 3);
        phase(P_IDLE, 4, -1, 1'b0, 5, 0);
        settle("dur");
        check("dur_trig_errors", n_trig,       0);
        check("dur_seq_errors",  n_seq,        0);
        check("dur_locked",      int'(locked), 1);
        do_reset();

        // Reset in mid-sequence, then relock
        run_seq(0, 8, 1'b1, -1, -1);
        phase(P_IDLE, 3, -1, 1'b0, 9, 0);
        do_reset();
        run_seq(9, 15, 1'b0, -1, -1);
        check("rr_locked_before", int'(locked), 0);
        run_seq(0, 15, 1'b1, -1, -1);
        phase(P_RPOS, 4, -1, 1'b0, 0, 1);
        settle("rr");
        check("rr_cycle_count", int'(cycle_count), 1);
        check("rr_error_count", int'(error_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
